// File: rtl/npc_ras_unit_if.sv
// Fetch-PC / return-address-stack bundle between the pipeline control
// (hazard unit, IF predecoder, EX stage) and npc_ras_unit.
interface npc_ras_unit_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OP_W = 3
);
  logic            stall;
  logic            if_is_ret;
  logic            ex_valid;
  logic [OP_W-1:0] ex_npc_op;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rs1;
  logic            ex_is_call;
  logic            ex_is_ret;
  logic            ex_pred_used;
  logic [XLEN-1:0] ex_pred_target;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            pred_used;
  logic [XLEN-1:0] pred_target;
  logic            flush;

  modport master (
    output stall, if_is_ret, ex_valid, ex_npc_op, ex_pc, ex_imm, ex_rs1,
           ex_is_call, ex_is_ret, ex_pred_used, ex_pred_target,
    input  pc, pc_plus4, pred_used, pred_target, flush
  );

  modport slave (
    input  stall, if_is_ret, ex_valid, ex_npc_op, ex_pc, ex_imm, ex_rs1,
           ex_is_call, ex_is_ret, ex_pred_used, ex_pred_target,
    output pc, pc_plus4, pred_used, pred_target, flush
  );
endinterface

// File: rtl/npc_ras_unit.sv
// Fetch-PC generator with a circular return-address stack: IF predicts
// returns from the stack top, EX verifies them and updates the stack.
module npc_ras_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter int unsigned     OP_W      = 3
) (
  input logic          clk,
  input logic          rst,
  npc_ras_unit_if.slave bus
);

  localparam logic [OP_W-1:0] NPC_PLUS4  = OP_W'(0);
  localparam logic [OP_W-1:0] NPC_BRANCH = OP_W'(1);
  localparam logic [OP_W-1:0] NPC_JUMP   = OP_W'(2);
  localparam logic [OP_W-1:0] NPC_JALR   = OP_W'(4);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] pc_plus4;

  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   ptr_nxt;
  logic [PW:0]     count_q;
  logic [PW:0]     count_nxt;
  logic            ras_empty;
  logic [XLEN-1:0] ras_top;

  logic            ras_we;
  logic [PW-1:0]   ras_widx;
  logic [XLEN-1:0] link_addr;
  logic            push;
  logic            pop;

  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] redirect_tgt;
  logic            is_branch;
  logic            is_jump;
  logic            is_jalr;
  logic            jalr_hit;
  logic            redirect;
  logic            predict;

  // ---------------------------------------------------------------------
  // EX target resolution and redirect decision
  // ---------------------------------------------------------------------
  always_comb begin
    is_branch = (bus.ex_npc_op == NPC_BRANCH);
    is_jump   = (bus.ex_npc_op == NPC_JUMP);
    is_jalr   = (bus.ex_npc_op == NPC_JALR);

    br_tgt    = bus.ex_pc + bus.ex_imm;
    jalr_sum  = bus.ex_rs1 + bus.ex_imm;
    jalr_tgt  = {jalr_sum[XLEN-1:1], 1'b0};

    // A correctly predicted return already fetched down the right path.
    jalr_hit  = bus.ex_pred_used && (bus.ex_pred_target == jalr_tgt);

    redirect  = bus.ex_valid && (is_branch || is_jump || (is_jalr && !jalr_hit));
    redirect_tgt = is_jalr ? jalr_tgt : br_tgt;
  end

  // ---------------------------------------------------------------------
  // Return prediction and next-PC select
  // ---------------------------------------------------------------------
  always_comb begin
    ras_empty = (count_q == '0);
    ras_top   = ras_empty ? '0 : ras[ptr_q];
    pc_plus4  = pc_q + XLEN'(4);

    predict   = bus.if_is_ret && !ras_empty && !bus.stall && !redirect && !rst;

    pc_nxt = pc_plus4;
    if (redirect) begin
      pc_nxt = redirect_tgt;
    end else if (bus.stall) begin
      pc_nxt = pc_q;
    end else if (bus.if_is_ret && !ras_empty) begin
      pc_nxt = ras_top;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // RAS update, driven only by retiring EX instructions
  // ---------------------------------------------------------------------
  always_comb begin
    push      = bus.ex_valid && bus.ex_is_call;
    pop       = bus.ex_valid && bus.ex_is_ret;
    link_addr = bus.ex_pc + XLEN'(4);

    ras_we    = 1'b0;
    ras_widx  = ptr_q;
    ptr_nxt   = ptr_q;
    count_nxt = count_q;

    // Combined push+pop replaces the top in place; on an empty stack it
    // degenerates to a plain push. A full push wraps over the oldest entry.
    if (push && (!pop || ras_empty)) begin
      ras_we    = 1'b1;
      ras_widx  = ptr_q + PW'(1);
      ptr_nxt   = ptr_q + PW'(1);
      if (count_q != FULL_CNT) begin
        count_nxt = count_q + (PW + 1)'(1);
      end
    end else if (push && pop) begin
      ras_we    = 1'b1;
      ras_widx  = ptr_q;
    end else if (pop && !ras_empty) begin
      ptr_nxt   = ptr_q - PW'(1);
      count_nxt = count_q - (PW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        ras[i] <= '0;
      end
    end else begin
      ptr_q   <= ptr_nxt;
      count_q <= count_nxt;
      if (ras_we) begin
        ras[ras_widx] <= link_addr;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.pred_used   = predict;
  assign bus.pred_target = ras_top;
  assign bus.flush       = redirect && !rst;

endmodule
